// File: rtl/image_rom_pkg.sv
// Shared types and constants for the raw-image ROM read path.
//   ADDR_W / DATA_W     : ROM byte-address and pixel widths
//   IMG_BYTES           : number of valid image bytes (400x400)
//   ROM_LATENCY_DEF     : default edges from ROM address sample to valid rom_q
//   rom_addr_t / pix_t  : address and pixel types
//   rd_tag_t            : per-read tag travelling alongside the ROM access
package image_rom_pkg;

    localparam int ADDR_W          = 18;
    localparam int DATA_W          = 8;
    localparam int IMG_BYTES       = 160000;
    localparam int ROM_LATENCY_DEF = 1;

    typedef logic [ADDR_W-1:0] rom_addr_t;
    typedef logic [DATA_W-1:0] pix_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic oor;
    } rd_tag_t;

    // An address at or beyond the image size has no pixel behind it.
    function automatic logic addr_oor(input rom_addr_t a);
        return 32'(a) >= 32'(IMG_BYTES);
    endfunction

endpackage

// File: rtl/image_rom_arbiter_rr_arbiter2.sv
// Two-way round-robin grant.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request valids (bit 0 = requester 0)
//   gnt[1:0] : one-hot or zero grant, only ever on a requesting bit
// The grant is the accept: the pointer moves on every cycle a grant is given.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Id of the requester granted most recently; 1 after reset so that
    // requester 0 wins the first contention.
    logic last_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (|gnt) begin
            last_gnt <= gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req[0] && (!req[1] || last_gnt)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_rom_arbiter.sv
// Shares the single-port raw-image ROM between the pixel engine (requester 0)
// and the display reader (requester 1).
//   clk, rst                    : clock, synchronous active-high reset
//   reqN_valid/reqN_addr        : read request from requester N
//   reqN_ready                  : request N accepted this cycle
//   rspN_valid/rspN_data/rspN_err : one-cycle response strobe, data, out-of-range flag
//   rom_addr                    : address to the ROM (sampled by the ROM every edge)
//   rom_q                       : ROM read data, ROM_LATENCY edges after address sample
// Every accepted read returns exactly ROM_LATENCY+1 cycles later to its own
// requester; out-of-range reads return 0x00 with err set and never touch the ROM.
module image_rom_arbiter
    import image_rom_pkg::*;
#(
    parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q
);

    logic [1:0] gnt;
    logic       gnt_any;
    logic       gnt_id;
    rom_addr_t  gnt_addr;
    logic       gnt_oor;
    rom_addr_t  rom_addr_p0;
    rd_tag_t    tag_p [ROM_LATENCY+1];
    rd_tag_t    cap_tag;
    rd_tag_t    out_tag;
    pix_t       cap_pix;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign gnt_any  = |gnt;
    assign gnt_id   = gnt[1];
    assign gnt_addr = gnt_id ? req1_addr : req0_addr;
    assign gnt_oor  = addr_oor(gnt_addr);

    // Grant cycle: the granted in-range address goes straight to the ROM so it
    // is sampled at the accept edge; otherwise the last address is replayed so
    // the ROM input does not toggle.
    always_comb begin
        rom_addr = rom_addr_p0;
        if (gnt_any && !gnt_oor) begin
            rom_addr = gnt_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_p0 <= '0;
        end else begin
            rom_addr_p0 <= rom_addr;
        end
    end

    // Tag stages: tag_p[k] describes the read accepted k+1 edges ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ROM_LATENCY; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= '{valid: gnt_any, id: gnt_id, oor: gnt_oor};
            for (int i = 1; i <= ROM_LATENCY; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    // Capture stage: rom_q for the read in tag_p[ROM_LATENCY-1] is valid now.
    assign cap_tag = tag_p[ROM_LATENCY-1];
    assign cap_pix = cap_tag.oor ? '0 : rom_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_data <= '0;
            rsp0_err  <= 1'b0;
            rsp1_data <= '0;
            rsp1_err  <= 1'b0;
        end else if (cap_tag.valid) begin
            if (cap_tag.id) begin
                rsp1_data <= cap_pix;
                rsp1_err  <= cap_tag.oor;
            end else begin
                rsp0_data <= cap_pix;
                rsp0_err  <= cap_tag.oor;
            end
        end
    end

    // Output stage: the strobe follows the last tag stage, aligned with the data.
    assign out_tag    = tag_p[ROM_LATENCY];
    assign rsp0_valid = out_tag.valid && !out_tag.id;
    assign rsp1_valid = out_tag.valid &&  out_tag.id;

endmodule

// File: tb/tb_image_rom_arbiter.sv
module tb_image_rom_arbiter;
    import image_rom_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic              rsp0_err, rsp1_err;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;

    always #5 clk = ~clk;

    image_rom_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q)
    );

    // ROM contents: an address-dependent pattern, nonzero at address 0.
    function automatic logic [7:0] rom_fn(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h5A;
    endfunction

    // ROM: registered address, unregistered output.
    always @(posedge clk) rom_q <= rom_fn(rom_addr);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected responses as a time-ordered list.
    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t        pend[$];
    int          last_served = 1;
    int          cyc = 0;
    logic [7:0]  m_data [2];
    logic [17:0] m_addr = '0;
    bit          live = 0;

    task automatic step(input bit r, input bit v0, input logic [17:0] a0,
                        input bit v1, input logic [17:0] a1);
        int          g;
        logic [17:0] ga;
        bit          oor;
        bit          e0, e1;
        logic        eerr;
        rsp_t        p;
        @(negedge clk);
        rst = r; req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
        #1;
        g = -1;
        if (!r) begin
            if (v0 && v1) g = 1 - last_served;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        ga  = (g == 1) ? a1 : a0;
        oor = (ga >= 18'd160000);
        chk("ready0", {31'b0, req0_ready}, {31'b0, g == 0});
        chk("ready1", {31'b0, req1_ready}, {31'b0, g == 1});
        if (live) begin
            chk("rom_addr", 32'(rom_addr), 32'((g >= 0 && !oor) ? ga : m_addr));
            e0 = 0; e1 = 0; eerr = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                m_data[p.id] = p.data;
                eerr = p.err;
                if (p.id == 0) e0 = 1; else e1 = 1;
            end
            chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, e0});
            chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, e1});
            chk("rsp0_data", 32'(rsp0_data), 32'(m_data[0]));
            chk("rsp1_data", 32'(rsp1_data), 32'(m_data[1]));
            if (e0) chk("rsp0_err", {31'b0, rsp0_err}, {31'b0, eerr});
            if (e1) chk("rsp1_err", {31'b0, rsp1_err}, {31'b0, eerr});
        end
        if (r) begin
            pend.delete();
            m_data[0] = '0; m_data[1] = '0;
            last_served = 1;
            m_addr = '0;
            live = 1;
        end else if (g >= 0) begin
            last_served = g;
            if (!oor) m_addr = ga;
            pend.push_back('{due: cyc + 2, id: g, data: oor ? 8'h00 : rom_fn(ga), err: oor});
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 18'd0, 0, 18'd0);
    endtask

    function automatic logic [17:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 18'($urandom_range(0, 159999));
            1:       return 18'(159990 + $urandom_range(0, 20));
            2:       return 18'($urandom);
            default: return 18'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_addr = '0; req1_valid = 0; req1_addr = '0;
        m_data[0] = '0; m_data[1] = '0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Single read from requester 0
        step(0, 1, 18'd0, 0, 18'd0);
        idle(3);

        // Continuous contention, grants alternate starting at 0
        for (int i = 0; i < 6; i++) step(0, 1, 18'd4, 1, 18'd159992);
        idle(3);

        // Requester 1 streams back-to-back
        for (int i = 0; i < 4; i++) step(0, 0, 18'd0, 1, 18'(12 + 4 * i));
        idle(3);

        // Out-of-range then last in-range address
        step(0, 1, 18'd160000, 0, 18'd0);
        step(0, 1, 18'd159999, 0, 18'd0);
        step(0, 0, 18'd0, 1, 18'd262143);
        idle(3);

        // Reset with three reads in flight
        step(0, 1, 18'd100, 0, 18'd0);
        step(0, 0, 18'd0, 1, 18'd200);
        step(0, 1, 18'd300, 0, 18'd0);
        step(1, 0, 18'd0, 0, 18'd0);
        step(0, 1, 18'd40, 1, 18'd44);
        idle(3);

        // Sparse traffic: pointer holds across idle gaps
        step(0, 1, 18'd8, 0, 18'd0);
        idle(2);
        step(0, 1, 18'd9, 1, 18'd10);
        idle(2);
        step(0, 0, 18'd0, 1, 18'd11);
        idle(2);
        step(0, 1, 18'd12, 1, 18'd13);
        idle(3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), rand_addr(),
                 ($urandom_range(0, 2) != 0), rand_addr());
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/image_rom_arbiter.md
Name: image_rom_arbiter

Overview:
- Shares the single-port raw-image ROM (18-bit byte address, 8-bit data, registered address) between two read requesters.
  - Requester 0: pixel-processing engine.
  - Requester 1: output/display reader.
- Per-requester valid/ready request channel, fair round-robin grant, tagged read pipeline.
- Each requester gets back only its own responses, in order.
- Sits between the ROM wrapper and the image datapath; the only block that drives the ROM address.

Parameters:
- ADDR_W, 18, ROM byte-address width.
- DATA_W, 8, pixel width.
- IMG_BYTES, 160000, valid image size (400x400); addresses >= IMG_BYTES are out of range.
- ROM_LATENCY, 1, edges from ROM address sample to valid rom_q (registered address, unregistered output = 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 read request
- req0_addr  in  ADDR_W  requester 0 byte address
- req0_ready  out  1  requester 0 request accepted this cycle
- rsp0_valid  out  1  requester 0 response strobe
- rsp0_data  out  DATA_W  requester 0 read data
- rsp0_err  out  1  requester 0 out-of-range flag, qualified by rsp0_valid
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_err: same as above, for requester 1
- rom_addr  out  ADDR_W  address to ROM
- rom_q  in  DATA_W  ROM read data

Behaviour:
- **Reset** (rst high at an edge) clears:
  - rsp*_valid = 0, rsp*_data = 0, rsp*_err = 0.
  - Round-robin pointer set to "last granted = 1", so requester 0 wins the first contention.
  - Tag pipeline cleared. In-flight reads are discarded and never produce a response.
  - rom_addr register = 0.
- **Ready rules:**
  - req*_ready is combinational from req*_valid and the pointer.
  - At most one ready per cycle.
  - Ready is never asserted without the matching valid.
  - During rst, both readys are 0.
- **Arbitration:**
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester not granted most recently.
  - Pointer updates only on an accepted request (valid & ready at an edge).
  - Pointer holds through idle cycles.
- **Acceptance at edge t:**
  - In range: rom_addr is driven combinationally to the granted address in the grant cycle, so the ROM samples it at edge t.
  - Out of range: rom_addr holds its previous value.
  - When no grant, rom_addr holds its last value (no spurious toggling).
- **Tag pipeline:**
  - Depth ROM_LATENCY+1.
  - Each entry: {valid, id, oor}.
  - Shifted every cycle.
- **Response timing:**
  - rom_q is registered into rsp<id>_data at edge t+ROM_LATENCY.
  - rsp<id>_valid is high for exactly one cycle after edge t+ROM_LATENCY.
  - Fixed latency ROM_LATENCY+1 cycles from accept to response.
  - Oor entries return data 0x00 with err=1 at the same latency; the ROM data is ignored.
  - The non-addressed requester's rsp_valid stays 0; its rsp_data holds.
- **Throughput:** one accept per cycle total; back-to-back accepts produce back-to-back responses.
- **Requesters have no backpressure on responses.** A requester must accept every rsp strobe.
- **Boundaries:**
  - Address 159999 is in range; 160000 and 262143 are out of range.
  - Simultaneous request and response to the same requester is legal.
  - A requester holding valid high with changing addr gets whichever addr is present on its ready cycle.
  - rst asserted while the pipeline is full suppresses all pending strobes from the next cycle.

Decomposition:
- Package image_rom_pkg:
  - ADDR_W, DATA_W, IMG_BYTES constants.
  - Typedef rom_addr_t (logic [ADDR_W-1:0]) and pix_t (logic [DATA_W-1:0]).
  - Struct rd_tag_t {valid, id, oor}.
- One sub-module, rr_arbiter2: 2-way round-robin grant with pointer, reset and update-on-accept.
- Tag pipeline and address mux stay in the top.

Test Plan:
1. Reset, then req0 addr 0 alone -> req0_ready same cycle; rsp0_valid 2 cycles after accept with ROM[0], err=0; rsp1_valid stays 0.
2. Both valid continuously: req0 at 4, req1 at 159992 -> grants alternate 0,1,0,1 starting with 0; responses alternate with 2-cycle latency and correct data per requester; no cycle with both readys.
3. req1 streams addrs 12, 16, 20, 24 back-to-back, req0 idle -> four consecutive accepts, then four consecutive rsp1 strobes in order with ROM[12..24].
4. req0 addr 160000, then 159999 -> first response data 0x00, err=1, rom_addr unchanged; second response ROM[159999], err=0.
5. Three reads in flight, rst pulsed 1 cycle -> no rsp strobes after the reset edge; next requester-0/1 contention grants 0 first.
6. Alternating sparse requests with idle gaps -> pointer holds across idles; the grant after contention goes to the requester not served last; rom_addr stable during idles.
